// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair.
// Shift-add multiply or restoring divide over 32 steps, then a one-cycle sign fix-up.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               sign_quo_q, sign_quo_d;
    logic               sign_rem_q, sign_rem_d;
    logic               done_q, done_d;

    logic               accept;
    logic               is_muldiv;
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               cnt_zero;

    assign accept    = start && (state_q == S_IDLE);
    assign is_muldiv = ~op[2];
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
    assign cnt_zero  = (cnt_q == '0);

    // Multiply step: acc holds {partial sum, remaining multiplier bits}, LSB first.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc holds {remainder, dividend/quotient}; quotient bits enter at the LSB.
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] div_next;

    assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_ge    = (rem_shift >= {1'b0, opnd_q});
    assign rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;
    assign div_next  = rem_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {acc_q[2*WIDTH-2:0], 1'b0};

    // Fix-up values applied in the final cycle.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = sign_quo_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    assign quo_fix  = sign_quo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    assign rem_fix  = sign_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                                 : acc_q[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_muldiv) begin
                    state_d = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_zero) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath next-state
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        div0_d     = div0_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        done_d     = (state_q == S_FIX);

        case (state_q)
            S_IDLE: begin
                if (accept && is_muldiv) begin
                    // Divide keeps the divisor in opnd; multiply keeps the multiplicand.
                    opnd_d     = op[1] ? b_mag : a_mag;
                    acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    cnt_d      = CW'(WIDTH - 1);
                    is_div_d   = op[1];
                    div0_d     = op[1] && (b == '0);
                    sign_quo_d = a_neg ^ b_neg;
                    sign_rem_d = a_neg;
                end else if (accept && (op == OP_MTHI)) begin
                    hi_d = a;
                end else if (accept && (op == OP_MTLO)) begin
                    lo_d = a;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CW'(1);
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - CW'(1);
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div0_q) begin
                    // Remainder ended up as |a|; restoring the sign yields the raw dividend.
                    hi_d = rem_fix;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            div0_q     <= 1'b0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            div0_q     <= div0_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, random ops against a
// plain-arithmetic reference, MTHI/MTLO, busy-time ignores and async reset.
module tb_muldiv_unit;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     res;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        ua = {32'h0, x};
        ub = {32'h0, y};
        res = 64'h0;
        case (o)
            MULT: begin
                sp  = sa * sb;
                res = sp;
            end
            MULTU: begin
                up  = ua * ub;
                res = up;
            end
            DIV: begin
                if (y == 32'h0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            DIVU: begin
                if (y == 32'h0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
            default: res = 64'h0;
        endcase
        return res;
    endfunction

    // Issues one mul/div starting at the current negedge and returns what it observed,
    // ending at the negedge where done is seen (or after the cycle budget, lat=0).
    task automatic exec_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic busy0, output logic done0, output logic hold_ok,
                           output int lat, output logic [31:0] rh, output logic [31:0] rl);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        done0 = done;
        hold_ok = (hi === h0) && (lo === l0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if ((hi !== h0) || (lo !== l0)) hold_ok = 1'b0;
        end
        rh = hi;
        rl = lo;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        op = 3'b000;
        a = 32'h0;
        b = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h required 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h required 00000000", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    endtask

    task automatic test_directed;
        logic [2:0]  t_op [7] = '{MULTU, MULT, MULT, DIV, DIVU, DIV, DIVU};
        logic [31:0] t_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFF9,
                                  32'd7, 32'h80000000, 32'h12345678};
        logic [31:0] t_b  [7] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB, 32'd2,
                                  32'd2, 32'hFFFFFFFF, 32'h0};
        logic [31:0] t_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
                                  32'd1, 32'h0, 32'h12345678};
        logic [31:0] t_lo [7] = '{32'h00000001, 32'hFFFFFFF1, 32'h0000000F, 32'hFFFFFFFD,
                                  32'd3, 32'h80000000, 32'hFFFFFFFF};
        logic b0, d0, hok;
        int lat;
        logic [31:0] rh, rl;
        for (int k = 0; k < 7; k++) begin
            exec_op(t_op[k], t_a[k], t_b[k], b0, d0, hok, lat, rh, rl);
            $display("directed[%0d]: op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", k, t_op[k], t_a[k], t_b[k], rh, rl, lat);
            n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy: got %b required 1", k, b0); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL dir%0d_latency: got %0d required 33", k, lat); end
            n_cmp++; if (hok !== 1'b1) begin n_err++; $display("FAIL dir%0d_hold: got %b required 1", k, hok); end
            n_cmp++; if (rh !== t_hi[k]) begin n_err++; $display("FAIL dir%0d_hi: got %h required %h", k, rh, t_hi[k]); end
            n_cmp++; if (rl !== t_lo[k]) begin n_err++; $display("FAIL dir%0d_lo: got %h required %h", k, rl, t_lo[k]); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_end: got %b required 0", k, busy); end
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse: got %b required 0", k, done); end
        end
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] l0;
        l0 = lo;
        start = 1'b1; op = MTHI; a = 32'hAAAA5555; b = 32'h0;
        @(negedge clk);
        start = 1'b0;
        $display("mthi: hi=%h lo=%h busy=%b", hi, lo, busy);
        n_cmp++; if (hi !== 32'hAAAA5555) begin n_err++; $display("FAIL mthi_hi: got %h required aaaa5555", hi); end
        n_cmp++; if (lo !== l0) begin n_err++; $display("FAIL mthi_lo_kept: got %h required %h", lo, l0); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL mthi_busy_done: got %b required 00", {busy, done}); end
        start = 1'b1; op = MTLO; a = 32'h13572468;
        @(negedge clk);
        start = 1'b0;
        $display("mtlo: hi=%h lo=%h busy=%b", hi, lo, busy);
        n_cmp++; if (lo !== 32'h13572468) begin n_err++; $display("FAIL mtlo_lo: got %h required 13572468", lo); end
        n_cmp++; if (hi !== 32'hAAAA5555) begin n_err++; $display("FAIL mtlo_hi_kept: got %h required aaaa5555", hi); end
        for (int u = 6; u < 8; u++) begin
            start = 1'b1; op = 3'(u); a = 32'h55555555; b = 32'h3;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            $display("undef op %0d: hi=%h lo=%h busy=%b", u, hi, lo, busy);
            n_cmp++; if ({hi, lo, busy} !== {32'hAAAA5555, 32'h13572468, 1'b0})
                begin n_err++; $display("FAIL undef_op%0d: got %h/%h/%b required aaaa5555/13572468/0", u, hi, lo, busy); end
        end
    endtask

    task automatic test_ignore_while_busy;
        logic [31:0] h0, l0;
        logic [63:0] exp;
        int lat;
        h0 = hi;
        l0 = lo;
        exp = ref_model(MULTU, 32'hDEADBEEF, 32'h00C0FFEE);
        start = 1'b1; op = MULTU; a = 32'hDEADBEEF; b = 32'h00C0FFEE;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = MTLO; a = 32'h11112222;
        @(negedge clk);
        op = DIVU; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({hi, lo, busy} !== {h0, l0, 1'b1})
            begin n_err++; $display("FAIL busy_ignore_mid: got %h/%h/%b required %h/%h/1", hi, lo, busy, h0, l0); end
        lat = 0;
        for (int i = 7; i <= 45; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        $display("busy ignore: hi=%h lo=%h lat=%0d", hi, lo, lat);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL busy_ignore_latency: got %0d required 33", lat); end
        n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL busy_ignore_result: got %h required %h", {hi, lo}, exp); end
        @(negedge clk);
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL busy_ignore_after: got %b required 00", {busy, done}); end
    endtask

    task automatic test_random_back_to_back;
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        logic b0, d0, hok;
        int lat;
        logic [31:0] rh, rl;
        for (int k = 0; k < 24; k++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = ref_model(o, x, y);
            exec_op(o, x, y, b0, d0, hok, lat, rh, rl);
            $display("random[%0d]: op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", k, o, x, y, rh, rl, lat);
            n_cmp++; if ({b0, d0} !== 2'b10) begin n_err++; $display("FAIL rnd%0d_start_flags: got %b required 10", k, {b0, d0}); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL rnd%0d_latency: got %0d required 33", k, lat); end
            n_cmp++; if ({rh, rl} !== exp) begin n_err++; $display("FAIL rnd%0d_result: got %h required %h", k, {rh, rl}, exp); end
            // Odd iterations start the next op in the done cycle (first edge with busy=0).
            if (k[0] == 1'b0) @(negedge clk);
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rnd_done_pulse: got %b required 0", done); end
    endtask

    task automatic test_reset_mid_op;
        logic b0, d0, hok;
        int lat;
        logic [31:0] rh, rl;
        start = 1'b1; op = MTHI; a = 32'hDEAD0001;
        @(negedge clk);
        start = 1'b1; op = MULT; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-op: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL midrst_hi: got %h required 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL midrst_lo: got %h required 00000000", lo); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_busy_done: got %b required 00", {busy, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exec_op(MULTU, 32'd6, 32'd7, b0, d0, hok, lat, rh, rl);
        $display("after reset MULTU 6x7: hi=%h lo=%h lat=%0d", rh, rl, lat);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL postrst_latency: got %0d required 33", lat); end
        n_cmp++; if ({rh, rl} !== {32'h0, 32'd42}) begin n_err++; $display("FAIL postrst_result: got %h required %h", {rh, rl}, {32'h0, 32'd42}); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_mthi_mtlo;
        test_ignore_while_busy;
        test_random_back_to_back;
        test_reset_mid_op;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
